// File: rtl/clock_pkg.sv
// Shared types and constants for the clock-setting controller: FSM states,
// edit-field codes, BCD wrap limits and the reset time.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_AMPM = 3'd3,
    ST_COMMIT   = 3'd4
  } state_e;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_AMPM = 2'd3;

  localparam int HOUR_MIN = 1;
  localparam int HOUR_MAX = 12;
  localparam int MIN_MIN  = 0;
  localparam int MIN_MAX  = 59;

  localparam logic [3:0] RST_HOUR_TENS  = 4'd1;
  localparam logic [3:0] RST_HOUR_UNITS = 4'd2;
  localparam logic [3:0] RST_MIN_TENS   = 4'd0;
  localparam logic [3:0] RST_MIN_UNITS  = 4'd0;
  localparam logic       RST_IS_AM      = 1'b1;

endpackage

// File: rtl/bcd_wrap_inc.sv
// Combinational two-digit BCD increment that wraps from HI back to LO.
module bcd_wrap_inc #(
  parameter int LO = 0,
  parameter int HI = 59
) (
  input  logic [3:0] tens_i,
  input  logic [3:0] units_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o
);

  localparam logic [3:0] LO_T = 4'(LO / 10);
  localparam logic [3:0] LO_U = 4'(LO % 10);
  localparam logic [3:0] HI_T = 4'(HI / 10);
  localparam logic [3:0] HI_U = 4'(HI % 10);

  logic at_hi;
  assign at_hi = (tens_i == HI_T) && (units_i == HI_U);

  always_comb begin
    tens_o  = tens_i;
    units_o = units_i + 4'd1;
    if (at_hi) begin
      tens_o  = LO_T;
      units_o = LO_U;
    end else if (units_i >= 4'd9) begin
      tens_o  = tens_i + 4'd1;
      units_o = 4'd0;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks hour/minute/AM-PM edit fields, commits the
// edited time with a one-cycle load strobe, or abandons it after idle timeout.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] cur_hour_tens,
  input  logic [3:0] cur_hour_units,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_units,
  input  logic       cur_is_am,
  output logic [3:0] set_hour_tens,
  output logic [3:0] set_hour_units,
  output logic [3:0] set_min_tens,
  output logic [3:0] set_min_units,
  output logic       set_is_am,
  output logic       load_pulse,
  output logic       run_en,
  output logic [1:0] edit_field,
  output logic       blink,
  output logic [2:0] dbg_state
);

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT_S);

  state_e     state_q, state_d;
  logic [7:0] idle_q, idle_d;
  logic       blink_q, blink_d;
  logic [3:0] hour_t_q, hour_t_d, hour_u_q, hour_u_d;
  logic [3:0] min_t_q, min_t_d, min_u_q, min_u_d;
  logic       is_am_q, is_am_d;

  logic [3:0] hour_t_inc, hour_u_inc, min_t_inc, min_u_inc;
  logic [7:0] idle_inc;

  assign idle_inc = idle_q + 8'd1;

  bcd_wrap_inc #(.LO(HOUR_MIN), .HI(HOUR_MAX)) u_hour_inc (
    .tens_i  (hour_t_q),
    .units_i (hour_u_q),
    .tens_o  (hour_t_inc),
    .units_o (hour_u_inc)
  );

  bcd_wrap_inc #(.LO(MIN_MIN), .HI(MIN_MAX)) u_min_inc (
    .tens_i  (min_t_q),
    .units_i (min_u_q),
    .tens_o  (min_t_inc),
    .units_o (min_u_inc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      idle_q   <= 8'd0;
      blink_q  <= 1'b0;
      hour_t_q <= RST_HOUR_TENS;
      hour_u_q <= RST_HOUR_UNITS;
      min_t_q  <= RST_MIN_TENS;
      min_u_q  <= RST_MIN_UNITS;
      is_am_q  <= RST_IS_AM;
    end else begin
      state_q  <= state_d;
      idle_q   <= idle_d;
      blink_q  <= blink_d;
      hour_t_q <= hour_t_d;
      hour_u_q <= hour_u_d;
      min_t_q  <= min_t_d;
      min_u_q  <= min_u_d;
      is_am_q  <= is_am_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idle_d   = idle_q;
    blink_d  = blink_q;
    hour_t_d = hour_t_q;
    hour_u_d = hour_u_q;
    min_t_d  = min_t_q;
    min_u_d  = min_u_q;
    is_am_d  = is_am_q;

    case (state_q)
      ST_RUN: begin
        idle_d  = 8'd0;
        blink_d = 1'b0;
        if (btn_mode) begin
          state_d  = ST_SET_HOUR;
          hour_t_d = cur_hour_tens;
          hour_u_d = cur_hour_units;
          min_t_d  = cur_min_tens;
          min_u_d  = cur_min_units;
          is_am_d  = cur_is_am;
        end
      end

      ST_SET_HOUR, ST_SET_MIN, ST_SET_AMPM: begin
        if (btn_mode) begin
          // A mode press swallows any simultaneous increment.
          idle_d  = 8'd0;
          blink_d = 1'b0;
          case (state_q)
            ST_SET_HOUR: state_d = ST_SET_MIN;
            ST_SET_MIN:  state_d = ST_SET_AMPM;
            default:     state_d = ST_COMMIT;
          endcase
        end else begin
          if (tick_1hz) blink_d = ~blink_q;
          if (btn_inc) begin
            idle_d = 8'd0;
            case (state_q)
              ST_SET_HOUR: begin
                hour_t_d = hour_t_inc;
                hour_u_d = hour_u_inc;
              end
              ST_SET_MIN: begin
                min_t_d = min_t_inc;
                min_u_d = min_u_inc;
              end
              default: is_am_d = ~is_am_q;
            endcase
          end else if (tick_1hz) begin
            idle_d = idle_inc;
            if (idle_inc >= TIMEOUT_V) begin
              state_d = ST_RUN;
              idle_d  = 8'd0;
              blink_d = 1'b0;
            end
          end
        end
      end

      ST_COMMIT: begin
        state_d = ST_RUN;
        idle_d  = 8'd0;
        blink_d = 1'b0;
      end

      default: begin
        state_d = ST_RUN;
        idle_d  = 8'd0;
        blink_d = 1'b0;
      end
    endcase
  end

  logic in_set;
  assign in_set = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) ||
                  (state_q == ST_SET_AMPM);

  always_comb begin
    edit_field = FIELD_NONE;
    case (state_q)
      ST_SET_HOUR: edit_field = FIELD_HOUR;
      ST_SET_MIN:  edit_field = FIELD_MIN;
      ST_SET_AMPM: edit_field = FIELD_AMPM;
      default:     edit_field = FIELD_NONE;
    endcase
  end

  assign load_pulse     = (state_q == ST_COMMIT);
  assign run_en         = ~in_set;
  assign blink          = blink_q & in_set;
  assign set_hour_tens  = hour_t_q;
  assign set_hour_units = hour_u_q;
  assign set_min_tens   = min_t_q;
  assign set_min_units  = min_u_q;
  assign set_is_am      = is_am_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: edit walk, BCD wraps, button priority,
// idle timeout, asynchronous reset mid-edit and ignored increments in RUN.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] cur_hour_tens = 4'd0, cur_hour_units = 4'd0;
  logic [3:0] cur_min_tens = 4'd0, cur_min_units = 4'd0;
  logic       cur_is_am = 1'b0;
  logic [3:0] set_hour_tens, set_hour_units, set_min_tens, set_min_units;
  logic       set_is_am, load_pulse, run_en, blink;
  logic [1:0] edit_field;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt = 0;
  logic [16:0] load_val;

  clock_set_ctrl #(.TIMEOUT_S(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
    .btn_inc(btn_inc), .cur_hour_tens(cur_hour_tens),
    .cur_hour_units(cur_hour_units), .cur_min_tens(cur_min_tens),
    .cur_min_units(cur_min_units), .cur_is_am(cur_is_am),
    .set_hour_tens(set_hour_tens), .set_hour_units(set_hour_units),
    .set_min_tens(set_min_tens), .set_min_units(set_min_units),
    .set_is_am(set_is_am), .load_pulse(load_pulse), .run_en(run_en),
    .edit_field(edit_field), .blink(blink), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // load strobe monitor: counts strobes and keeps the committed time
  always @(posedge clk) begin
    if (load_pulse) begin
      load_cnt = load_cnt + 1;
      load_val = {set_hour_tens, set_hour_units, set_min_tens, set_min_units, set_is_am};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // driver: one clock with the given pulses, outputs settled 1 time unit after the edge
  task automatic cyc(input logic mode, input logic inc, input logic tick);
    @(negedge clk);
    btn_mode = mode;
    btn_inc  = inc;
    tick_1hz = tick;
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick_1hz = 1'b0;
  endtask

  task automatic set_cur(input logic [3:0] ht, input logic [3:0] hu,
                         input logic [3:0] mt, input logic [3:0] mu, input logic am);
    cur_hour_tens  = ht;
    cur_hour_units = hu;
    cur_min_tens   = mt;
    cur_min_units  = mu;
    cur_is_am      = am;
  endtask

  function automatic logic [15:0] hm();
    return {set_hour_tens, set_hour_units, set_min_tens, set_min_units};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lc;
    // reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_hm", hm(), 16'h1200);
    check("rst_am", set_is_am, 1);
    check("rst_run_en", run_en, 1);
    check("rst_field", edit_field, 0);
    check("rst_load", load_pulse, 0);
    check("rst_blink", blink, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // full edit walk from 11:58 PM to 01:01 AM
    set_cur(4'd1, 4'd1, 4'd5, 4'd8, 1'b0);
    cyc(1, 0, 0);
    check("walk_capture", hm(), 16'h1158);
    check("walk_am_cap", set_is_am, 0);
    check("walk_run_en_h", run_en, 0);
    check("walk_field_h", edit_field, 1);
    cyc(0, 1, 0);
    check("walk_hour_12", hm(), 16'h1258);
    cyc(0, 1, 0);
    check("walk_hour_wrap", hm(), 16'h0158);
    check("walk_am_kept", set_is_am, 0);
    cyc(1, 0, 0);
    check("walk_field_m", edit_field, 2);
    cyc(0, 1, 0);
    check("walk_min_59", hm(), 16'h0159);
    cyc(0, 1, 0);
    check("walk_min_wrap", hm(), 16'h0100);
    cyc(0, 1, 0);
    check("walk_min_01", hm(), 16'h0101);
    check("walk_run_en_m", run_en, 0);
    cyc(1, 0, 0);
    check("walk_field_a", edit_field, 3);
    cyc(0, 1, 0);
    check("walk_am_toggle", set_is_am, 1);
    check("walk_no_load_yet", load_cnt, 0);
    cyc(1, 0, 0);
    check("commit_load", load_pulse, 1);
    check("commit_run_en", run_en, 1);
    check("commit_field", edit_field, 0);
    cyc(0, 0, 0);
    check("commit_one_load", load_cnt, 1);
    check("commit_value", load_val, {16'h0101, 1'b1});
    check("commit_after_load", load_pulse, 0);

    // 09 -> 10, then minute 59 -> 00 keeps hour
    set_cur(4'd0, 4'd9, 4'd5, 4'd9, 1'b1);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("hour_09_10", hm(), 16'h1059);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    check("min_59_00", hm(), 16'h1000);

    // idle timeout (TIMEOUT_S = 3) with a button rescuing a pending tick
    cyc(0, 0, 1);
    check("blink_t1", blink, 1);
    cyc(0, 0, 1);
    check("blink_t2", blink, 0);
    cyc(0, 1, 1);
    check("tick_inc_stays", edit_field, 2);
    check("tick_inc_min", hm(), 16'h1001);
    lc = load_cnt;
    cyc(0, 0, 1);
    check("to_tick1", edit_field, 2);
    cyc(0, 0, 1);
    check("to_tick2", edit_field, 2);
    check("to_tick2_run_en", run_en, 0);
    cyc(0, 0, 1);
    check("to_tick3_field", edit_field, 0);
    check("to_tick3_run_en", run_en, 1);
    check("to_tick3_blink", blink, 0);
    cyc(0, 0, 0);
    check("to_no_load", load_cnt, lc);

    // mode and inc together in SET_HOUR; blink restarts on field change
    set_cur(4'd0, 4'd3, 4'd1, 4'd5, 1'b1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    check("blink_set_hour", blink, 1);
    cyc(0, 1, 0);
    check("hour_03_04", hm(), 16'h0415);
    cyc(1, 1, 0);
    check("both_field", edit_field, 2);
    check("both_hm", hm(), 16'h0415);
    check("both_blink", blink, 0);

    // async reset in SET_AMPM
    cyc(1, 0, 0);
    check("pre_rst_field", edit_field, 3);
    lc = load_cnt;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_field", edit_field, 0);
    check("arst_run_en", run_en, 1);
    check("arst_hm", hm(), 16'h1200);
    check("arst_am", set_is_am, 1);
    check("arst_load", load_pulse, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // first mode after release is honoured on the first edge
    set_cur(4'd0, 4'd7, 4'd4, 4'd2, 1'b0);
    cyc(1, 0, 0);
    check("post_rst_mode", edit_field, 1);
    check("arst_no_load", load_cnt, lc);
    check("post_rst_cap", hm(), 16'h0742);

    // commit unchanged, then increments in RUN are ignored
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("commit2_val", load_val, {16'h0742, 1'b0});
    lc = load_cnt;
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("run_inc_hm", hm(), 16'h0742);
    check("run_inc_am", set_is_am, 0);
    check("run_inc_state", dbg_state, 0);
    check("run_inc_field", edit_field, 0);
    check("run_inc_load", load_cnt, lc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_S, default 30, is the number of 1 Hz ticks with no button activity before an edit is abandoned; legal range 2..255.
REQ-002 clk  in  1  system clock; the block has exactly one clock.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 tick_1hz  in  1  single-cycle 1 Hz pulse, synchronous to clk.
REQ-005 btn_mode  in  1  single-cycle debounced pulse; advances the edit field.
REQ-006 btn_inc  in  1  single-cycle debounced pulse; increments the field under edit.
REQ-007 cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units  in  4 each  live BCD time from the clock datapath.
REQ-008 cur_is_am  in  1  live AM/PM flag (1 = AM).
REQ-009 set_hour_tens, set_hour_units, set_min_tens, set_min_units  out  4 each  edit/load BCD values.
REQ-010 set_is_am  out  1  edit/load AM/PM flag.
REQ-011 load_pulse  out  1  single-cycle strobe that commits the set_* values and clears seconds to 00.
REQ-012 run_en  out  1  1 = time counters advance; 0 = counters frozen.
REQ-013 edit_field  out  2  field under edit: 0 = none, 1 = hour, 2 = minute, 3 = AM/PM.
REQ-014 blink  out  1  display blank strobe for the field under edit.

Function
REQ-015 FSM states: RUN, SET_HOUR, SET_MIN, SET_AMPM, COMMIT.
REQ-016 RUN + btn_mode transitions to SET_HOUR on the next cycle, and all set_* registers capture the cur_* inputs in that same cycle.
REQ-017 Transitions on btn_mode: SET_HOUR -> SET_MIN -> SET_AMPM -> COMMIT.
REQ-018 COMMIT lasts exactly one cycle, asserts load_pulse, then goes to RUN; load_pulse is asserted in no other state.
REQ-019 run_en = 1 in RUN and COMMIT, and 0 in all SET_* states.
REQ-020 edit_field = 0 in RUN and COMMIT, and 1/2/3 in SET_HOUR/SET_MIN/SET_AMPM respectively.
REQ-021 btn_inc in SET_HOUR increments the hour in BCD over 01..12: 09 -> 10, 12 -> 01; the hour never reads 00.
REQ-022 btn_inc in SET_MIN increments the minute in BCD over 00..59: 09 -> 10, 59 -> 00.
REQ-023 A minute wrap does not change the hour, and an hour wrap does not change set_is_am.
REQ-024 btn_inc in SET_AMPM toggles set_is_am.
REQ-025 btn_inc in RUN or COMMIT is ignored.
REQ-026 The result of an increment is visible on set_* one cycle after the btn_inc pulse.
REQ-027 If btn_mode and btn_inc occur in the same cycle, btn_mode wins and the increment is discarded.
REQ-028 An idle counter (8-bit) clears on entry to SET_HOUR and on every btn_mode or btn_inc pulse, and increments on tick_1hz while in a SET_* state.
REQ-029 When the idle counter reaches TIMEOUT_S, the FSM returns to RUN without a load_pulse, and the clock keeps its pre-edit time.
REQ-030 If a timeout and a button pulse fall in the same cycle, the button wins and the idle counter clears.
REQ-031 blink toggles on each tick_1hz in SET_* states, is forced to 0 in RUN/COMMIT, and restarts at 0 on every field change.
REQ-032 In RUN, set_* outputs hold their last values and are don't-care to the consumer.

Reset
REQ-033 While rst_n = 0: state = RUN; set_hour = 12 (tens 1, units 2); set_min = 00; set_is_am = 1; load_pulse = 0; run_en = 1; edit_field = 0; blink = 0; idle counter = 0.
REQ-034 Reset asserted mid-edit abandons the edit immediately, with no load_pulse.
REQ-035 The first btn_mode after reset deassertion is honoured on the first active edge.

Structure
REQ-036 Shared package clock_pkg holds: the state enumeration, the field-code constants (NONE/HOUR/MIN/AMPM), the BCD limits (HOUR_MIN = 1, HOUR_MAX = 12, MIN_MAX = 59) and the reset time constants.
REQ-037 One sub-module, bcd_wrap_inc, is instantiated for both the hour and minute paths; it performs a combinational 2-digit BCD increment with parameterised lower and upper wrap bounds.
REQ-038 The remainder of the block is a single FSM plus the idle and blink registers; target size is 150-300 lines of RTL.

Verification
REQ-039 Reset; cur = 11:58 PM; mode, inc×2, mode, inc×3, mode, inc, mode -> one load_pulse carrying 01:01 AM, and run_en low from the first mode until COMMIT.
REQ-040 Hour 09, one inc -> 10; hour 12, one inc -> 01; minute 59, one inc -> 00 with the hour unchanged.
REQ-041 Mode and inc in the same cycle while in SET_HOUR -> state becomes SET_MIN and the hour is unchanged.
REQ-042 TIMEOUT_S = 3; enter SET_MIN and apply no buttons -> back in RUN on the 3rd tick_1hz, with no load_pulse and run_en = 1.
REQ-043 rst_n pulsed low while in SET_AMPM -> all outputs take their reset values asynchronously, and no load_pulse occurs.
REQ-044 btn_inc pulses in RUN -> set_*, load_pulse and the state are all unchanged.
